aed_rhythm_detector: RTL and testbench

Front-end rhythm analyser for the defibrillator. It converts a raw per-beat pulse from the sensing electrode into the `H` (heartbeat present) and `R` (rhythm regular) levels that the AED control FSM consumes. Internally it measures inter-beat intervals with a saturating counter and tracks presence and regularity with a three-state machine. It sits between the sensor conditioning logic and the AED control FSM, and is the producer end of that FSM's H/R interface.

---
 rtl/aed_pkg.sv | 9 +
 rtl/aed_interval_timer.sv | 21 ++
 rtl/aed_rhythm_detector.sv | 111 +++++++++++
 tb/tb_aed_rhythm_detector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aed_pkg.sv
// aed_pkg: shared state type and default parameters for the rhythm detector
package aed_pkg;
    typedef enum logic [1:0] {ABSENT, ACQUIRE, TRACK} rhythm_state_t;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 200;
    localparam int DEF_MIN_INT = 10;
    localparam int DEF_TOL     = 8;
    localparam int DEF_NREG    = 2;
endpackage

// File: rtl/aed_interval_timer.sv
// aed_interval_timer: saturating interval counter, reloads to 1 on each accepted beat
module aed_interval_timer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 200
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_timeout
);
    logic [CNT_W-1:0] r_cnt;
    // Count cycles since the last load, holding at TIMEOUT once reached
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= CNT_W'(1);
        else if (r_cnt < CNT_W'(TIMEOUT)) r_cnt <= r_cnt + CNT_W'(1);
    end
    assign o_cnt     = r_cnt;
    assign o_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/aed_rhythm_detector.sv
// aed_rhythm_detector: turns raw beat pulses into heartbeat-present (H) and rhythm-regular (R) levels
// Define AED_RHYTHM_STATS_EN to add the irr_cnt output counting irregular intervals.
module aed_rhythm_detector
    import aed_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MIN_INT = DEF_MIN_INT,
    parameter int TOL     = DEF_TOL,
    parameter int NREG    = DEF_NREG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    output logic             H,
    output logic             R,
    output logic [CNT_W-1:0] ivl,
    output logic             ivl_valid
`ifdef AED_RHYTHM_STATS_EN
    ,
    output logic [7:0]       irr_cnt
`endif
);
    localparam int RUN_W = $clog2(NREG + 1);

    rhythm_state_t    r_state, w_state_n;
    logic             r_beat_q, w_rise, w_acc, w_tmo, w_upd, w_irr;
    logic             r_h, r_r, r_vld;
    logic [CNT_W-1:0] w_cnt, w_diff, r_prev, w_prev_n, r_ivl;
    logic [RUN_W-1:0] r_run, w_run_n;

    assign w_rise = beat & ~r_beat_q;
    assign w_acc  = w_rise & (r_state == ABSENT || w_cnt >= CNT_W'(MIN_INT));
    assign w_diff = (w_cnt > r_prev) ? w_cnt - r_prev : r_prev - w_cnt;

    aed_interval_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_load    (w_acc),
        .o_cnt     (w_cnt),
        .o_timeout (w_tmo)
    );

    // Presence/regularity FSM; a timeout outranks a coincident beat, which then restarts acquisition
    always_comb begin
        w_state_n = r_state;
        w_prev_n  = r_prev;
        w_run_n   = r_run;
        w_upd     = 1'b0;
        w_irr     = 1'b0;
        if (w_tmo) begin
            w_state_n = w_acc ? ACQUIRE : ABSENT;
            w_run_n   = '0;
        end else if (w_acc) begin
            case (r_state)
                ABSENT: w_state_n = ACQUIRE;
                ACQUIRE: begin
                    w_state_n = TRACK;
                    w_prev_n  = w_cnt;
                    w_run_n   = '0;
                    w_upd     = 1'b1;
                end
                TRACK: begin
                    w_prev_n = w_cnt;
                    w_upd    = 1'b1;
                    w_irr    = w_diff > CNT_W'(TOL);
                    w_run_n  = w_irr ? '0 : (r_run == RUN_W'(NREG)) ? r_run : r_run + RUN_W'(1);
                end
                default: w_state_n = ABSENT;
            endcase
        end
    end

    // State, interval history and all outputs registered on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_q <= 1'b0;
            r_state  <= ABSENT;
            r_prev   <= '0;
            r_run    <= '0;
            r_h      <= 1'b0;
            r_r      <= 1'b0;
            r_vld    <= 1'b0;
            r_ivl    <= '0;
        end else begin
            r_beat_q <= beat;
            r_state  <= w_state_n;
            r_prev   <= w_prev_n;
            r_run    <= w_run_n;
            r_h      <= w_state_n == TRACK;
            r_r      <= w_state_n == TRACK && w_run_n == RUN_W'(NREG);
            r_vld    <= w_upd;
            if (w_upd) r_ivl <= w_cnt;
        end
    end

    assign H         = r_h;
    assign R         = r_r;
    assign ivl       = r_ivl;
    assign ivl_valid = r_vld;

`ifdef AED_RHYTHM_STATS_EN
    logic [7:0] r_irr;
    // Saturating tally of irregular comparisons, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_irr <= '0;
        else if (w_irr && r_irr != 8'hFF) r_irr <= r_irr + 8'd1;
    end
    assign irr_cnt = r_irr;
`endif
endmodule

// File: tb/tb_aed_rhythm_detector.sv
// tb_aed_rhythm_detector: directed beats checked against a timestamp-based behavioural model
module tb_aed_rhythm_detector;
    localparam int TIMEOUT = 200;
    localparam int MIN_INT = 10;
    localparam int TOL     = 8;
    localparam int NREG    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        beat = 1'b0;
    logic        H, R, ivl_valid;
    logic [15:0] ivl;
`ifdef AED_RHYTHM_STATS_EN
    logic [7:0]  irr_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    aed_rhythm_detector dut (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .H         (H),
        .R         (R),
        .ivl       (ivl),
        .ivl_valid (ivl_valid)
`ifdef AED_RHYTHM_STATS_EN
        ,
        .irr_cnt   (irr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: beats are timestamps; interval is time since the last accepted beat, capped at TIMEOUT
    int   cyc = 0, last_t = 0, nb = 0, streak = 0, prev = 0, e = 0, irr = 0;
    bit   mbq = 0, rise = 0, acc = 0;
    logic exp_h = 0, exp_r = 0, exp_vld = 0;
    logic [15:0] exp_ivl = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            cyc = 0; last_t = 0; nb = 0; streak = 0; prev = 0; mbq = 0; irr = 0;
            exp_h = 0; exp_r = 0; exp_ivl = 0; exp_vld = 0;
        end else begin
            rise = beat && !mbq;
            mbq = beat;
            e = cyc - last_t;
            if (e > TIMEOUT) e = TIMEOUT;
            acc = rise && (nb == 0 || e >= MIN_INT);
            exp_vld = 0;
            if (e == TIMEOUT - 1) begin
                nb = acc ? 1 : 0;
                streak = 0;
            end else if (acc) begin
                if (nb >= 1) begin
                    exp_vld = 1;
                    exp_ivl = 16'(e);
                    if (nb >= 2) begin
                        if ((e > prev ? e - prev : prev - e) <= TOL) streak = (streak < NREG) ? streak + 1 : NREG;
                        else begin
                            streak = 0;
                            if (irr < 255) irr++;
                        end
                    end else streak = 0;
                    prev = e;
                end
                if (nb < 2) nb++;
            end
            if (acc) last_t = cyc;
            cyc++;
            exp_h = nb >= 2;
            exp_r = nb >= 2 && streak == NREG;
        end
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        n_chk++;
        if ({H, R, ivl, ivl_valid} !== {exp_h, exp_r, exp_ivl, exp_vld}) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got H=%b R=%b ivl=%0d vld=%b, expected H=%b R=%b ivl=%0d vld=%b",
                     $time, H, R, ivl, ivl_valid, exp_h, exp_r, exp_ivl, exp_vld);
        end
`ifdef AED_RHYTHM_STATS_EN
        n_chk++;
        if (irr_cnt !== 8'(irr)) begin
            n_fail++;
            $display("FAIL irr_cnt t=%0t: got %0d, expected %0d", $time, irr_cnt, irr);
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold the previous beat high for hi cycles, raise the next beat n cycles after the previous
    // rise, and return one cycle later once the outputs reflect it
    task automatic pulse(input int n, input int hi = 1);
        repeat (hi - 1) @(negedge clk);
        beat = 1'b0;
        repeat (n - hi) @(negedge clk);
        beat = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_H", 32'(H), 0);
        chk("reset_ivl", 32'(ivl), 0);
        reset = 1'b1;

        pulse(20);
        chk("first_H", 32'(H), 0);
        chk("first_vld", 32'(ivl_valid), 0);
        pulse(50);
        chk("rise2_H", 32'(H), 1);
        chk("rise2_ivl", 32'(ivl), 50);
        chk("rise2_vld", 32'(ivl_valid), 1);
        chk("rise2_R", 32'(R), 0);
        pulse(50);
        chk("rise3_R", 32'(R), 0);
        pulse(50);
        chk("rise4_R", 32'(R), 1);

        pulse(70);
        chk("irr_R", 32'(R), 0);
        chk("irr_H", 32'(H), 1);
        chk("irr_ivl", 32'(ivl), 70);
        pulse(70);
        chk("irr1_R", 32'(R), 0);
        pulse(70);
        chk("irr2_R", 32'(R), 1);

        pulse(5);
        chk("refr_vld", 32'(ivl_valid), 0);
        chk("refr_ivl", 32'(ivl), 70);
        chk("refr_R", 32'(R), 1);
        pulse(45);
        chk("refr_next_ivl", 32'(ivl), 50);
        chk("refr_next_vld", 32'(ivl_valid), 1);

        pulse(8);
        chk("min_minus1_vld", 32'(ivl_valid), 0);
        pulse(2);
        chk("min_exact_ivl", 32'(ivl), 10);
        chk("min_exact_vld", 32'(ivl_valid), 1);

        pulse(50, 30);
        chk("held_ivl", 32'(ivl), 50);
        pulse(50);
        pulse(50);
        chk("loss_pre_R", 32'(R), 1);
        beat = 1'b0;
        repeat (198) @(negedge clk);
        chk("loss_199_H", 32'(H), 1);
        @(negedge clk);
        chk("loss_200_H", 32'(H), 0);
        chk("loss_200_R", 32'(R), 0);
        pulse(20);
        chk("reacq1_H", 32'(H), 0);
        pulse(50);
        chk("reacq2_H", 32'(H), 1);

        pulse(199);
        chk("tmo_race_H", 32'(H), 0);
        chk("tmo_race_vld", 32'(ivl_valid), 0);
        pulse(50);
        chk("tmo_race_next_H", 32'(H), 1);
        chk("tmo_race_next_ivl", 32'(ivl), 50);
        pulse(198);
        chk("long_ivl", 32'(ivl), 198);
        chk("long_H", 32'(H), 1);

        pulse(50);
        chk("pre_rst_vld", 32'(ivl_valid), 1);
        #2;
        reset = 1'b0;
        beat = 1'b0;
        #1;
        chk("async_H", 32'(H), 0);
        chk("async_R", 32'(R), 0);
        chk("async_ivl", 32'(ivl), 0);
        chk("async_vld", 32'(ivl_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        pulse(30);
        chk("post_rst_H", 32'(H), 0);
        pulse(50);
        chk("post_rst2_H", 32'(H), 1);
        chk("post_rst2_ivl", 32'(ivl), 50);

`ifdef AED_RHYTHM_STATS_EN
        for (int i = 0; i < 300; i++) pulse((i % 2 == 0) ? 30 : 60);
        chk("irr_sat", 32'(irr_cnt), 255);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
